// File: rtl/clap_sense_controller.sv
// clap_sense_controller: calibrates the noise floor, publishes clap thresholds and gates the energy stream with a post-clap holdoff
module clap_sense_controller #(
    parameter int ENERGY_WIDTH    = 35,
    parameter int SUC_CLAPS_WIDTH = 16,
    parameter int CAL_LOG2        = 4,
    parameter int K_H_SHIFT       = 7,
    parameter int K_L_SHIFT       = 5,
    parameter int HOLDOFF_FRAMES  = 64,
    parameter int MIN_FLOOR       = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ENERGY_WIDTH-1:0]    energy_in_data,
    input  logic                       energy_in_valid,
    output logic                       energy_in_ready,
    output logic [ENERGY_WIDTH-1:0]    energy_out_data,
    output logic                       energy_out_valid,
    input  logic                       energy_out_ready,
    input  logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
    input  logic                       suc_claps_fire,
    input  logic                       recal_req,
    output logic [ENERGY_WIDTH-1:0]    thresh_high,
    output logic [ENERGY_WIDTH-1:0]    thresh_low,
    output logic                       config_valid,
    output logic                       state_calibrating,
    output logic                       state_holdoff
);
    localparam int AW = ENERGY_WIDTH + CAL_LOG2;
    localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [1:0] S_CAL   = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]                       r_state;
    logic [AW-1:0]                    r_acc;
    logic [CAL_LOG2-1:0]              r_cnt;
    logic [HW-1:0]                    r_hold;
    logic [ENERGY_WIDTH-1:0]          r_th;
    logic [ENERGY_WIDTH-1:0]          r_tl;
    logic                             r_cfg;
    logic                             r_pend;
    logic                             w_armed;
    logic                             w_accept;
    logic                             w_clap;
    logic                             w_svc;
    logic [AW-1:0]                    w_acc_nx;
    logic [ENERGY_WIDTH-1:0]          w_floor_raw;
    logic [ENERGY_WIDTH-1:0]          w_floor;
    logic [ENERGY_WIDTH+K_H_SHIFT-1:0] w_hi_wide;
    logic [ENERGY_WIDTH+K_L_SHIFT-1:0] w_lo_wide;
    logic [ENERGY_WIDTH-1:0]          w_th;
    logic [ENERGY_WIDTH-1:0]          w_tl;

    // Only ARMED passes frames through; CAL and HOLD swallow everything offered
    assign w_armed          = r_state == S_ARMED;
    assign energy_in_ready  = w_armed ? energy_out_ready : 1'b1;
    assign energy_out_valid = w_armed & energy_in_valid;
    assign energy_out_data  = w_armed ? energy_in_data : '0;
    assign w_accept         = energy_in_valid & energy_in_ready;
    assign w_clap           = suc_claps_fire & (|suc_claps_data);
    // Recalibration must not abandon a frame that is being offered downstream
    assign w_svc            = r_pend & (~w_armed | ~energy_in_valid | energy_out_ready);

    // Thresholds are derived from the sum including the frame accepted this cycle
    assign w_acc_nx    = r_acc + AW'(energy_in_data);
    assign w_floor_raw = w_acc_nx[AW-1:CAL_LOG2];
    assign w_floor     = (w_floor_raw < ENERGY_WIDTH'(MIN_FLOOR)) ? ENERGY_WIDTH'(MIN_FLOOR) : w_floor_raw;
    assign w_hi_wide   = {{K_H_SHIFT{1'b0}}, w_floor} << K_H_SHIFT;
    assign w_lo_wide   = {{K_L_SHIFT{1'b0}}, w_floor} << K_L_SHIFT;
    assign w_th        = (|w_hi_wide[ENERGY_WIDTH+K_H_SHIFT-1:ENERGY_WIDTH]) ? '1 : w_hi_wide[ENERGY_WIDTH-1:0];
    assign w_tl        = (|w_lo_wide[ENERGY_WIDTH+K_L_SHIFT-1:ENERGY_WIDTH]) ? '1 : w_lo_wide[ENERGY_WIDTH-1:0];

    assign thresh_high       = r_th;
    assign thresh_low        = r_tl;
    assign config_valid      = r_cfg;
    assign state_calibrating = r_state == S_CAL;
    assign state_holdoff     = r_state == S_HOLD;

    // Sequencer: recal service first, then per-state calibration, clap arming and holdoff counting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CAL;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_th    <= '0;
            r_tl    <= '0;
            r_cfg   <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= recal_req | (r_pend & ~w_svc);
            if (w_svc) begin
                r_state <= S_CAL;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_hold  <= '0;
                r_cfg   <= 1'b0;
            end else if (r_state == S_CAL) begin
                if (w_accept) begin
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_th    <= w_th;
                        r_tl    <= w_tl;
                        r_cfg   <= 1'b1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ARMED;
                    end
                end
            end else if (r_state == S_ARMED) begin
                if (w_clap) begin
                    r_state <= S_HOLD;
                    r_hold  <= '0;
                end
            end else begin
                if (w_clap) begin
                    r_hold <= '0;
                end else if (w_accept) begin
                    r_hold <= r_hold + 1'b1;
                    if (r_hold == HW'(HOLDOFF_FRAMES - 1)) begin
                        r_hold  <= '0;
                        r_state <= S_ARMED;
                    end
                end
            end
        end
    end
endmodule

// File: doc/clap_sense_controller.md
Name: clap_sense_controller

Overview:
Sequencing controller placed in-line on the energy stream between the energy computation stage and the clap decision stage.
- After reset or a recalibration request, it measures the ambient noise floor over a fixed number of energy frames.
- It derives the high and low clap thresholds from that floor and publishes them.
- It then forwards energy frames downstream.
- After any non-zero successive-clap report, it blanks the detector for a holdoff window so the light's own switching transient and room echo cannot re-trigger it.

Parameters:
ENERGY_WIDTH, 35, width of energy frames and thresholds.
SUC_CLAPS_WIDTH, 16, width of successive-claps count being monitored.
CAL_LOG2, 4, log2 of calibration frame count (16 frames).
K_H_SHIFT, 7, high threshold = floor << K_H_SHIFT (x128).
K_L_SHIFT, 5, low threshold = floor << K_L_SHIFT (x32).
HOLDOFF_FRAMES, 64, energy frames discarded after a clap report.
MIN_FLOOR, 1, lower clamp applied to the computed floor.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
energy_in_data  in  ENERGY_WIDTH  energy frame from upstream.
energy_in_valid  in  1  upstream valid.
energy_in_ready  out  1  ready to upstream.
energy_out_data  out  ENERGY_WIDTH  energy frame to clap decision stage.
energy_out_valid  out  1  downstream valid.
energy_out_ready  in  1  downstream ready.
suc_claps_data  in  SUC_CLAPS_WIDTH  tap of successive-claps stream.
suc_claps_fire  in  1  high for one cycle when a successive-claps handshake completes (tap only, never back-pressured).
recal_req  in  1  pulse requesting recalibration.
thresh_high  out  ENERGY_WIDTH  current high threshold.
thresh_low  out  ENERGY_WIDTH  current low threshold.
config_valid  out  1  thresholds valid; high from the first calibration's completion until the next calibration starts.
state_calibrating  out  1  state == CAL.
state_holdoff  out  1  state == HOLD.

Behaviour:
States and reset:
- States are CAL, ARMED and HOLD. Reset enters CAL.
- On reset: accumulator, frame counter, holdoff counter, thresholds and recal_pending = 0; config_valid = 0.

CAL:
- energy_in_ready = 1 and energy_out_valid = 0; frames are consumed, not forwarded.
- Each accepted frame is added to the accumulator (width ENERGY_WIDTH+CAL_LOG2, no overflow possible) and increments the frame counter.
- On the accept of frame 2^CAL_LOG2, the next cycle:
  - floor = max(acc >> CAL_LOG2, MIN_FLOOR);
  - thresh_high = floor << K_H_SHIFT and thresh_low = floor << K_L_SHIFT, each saturating to all-ones if any shifted-out bit is 1;
  - config_valid = 1, counters cleared, state = ARMED.

ARMED:
- Combinational pass-through: energy_out_data = energy_in_data, energy_out_valid = energy_in_valid, energy_in_ready = energy_out_ready. Zero latency, no buffering.
- If suc_claps_fire = 1 and suc_claps_data != 0: the next state is HOLD and the holdoff counter is cleared. A fire with data = 0 is ignored.

HOLD:
- energy_in_ready = 1 and energy_out_valid = 0; frames are discarded.
- The counter increments per accepted frame; after HOLDOFF_FRAMES accepts, state = ARMED.
- A suc_claps_fire with non-zero data during HOLD restarts the counter at 0.

Recalibration:
- recal_req sets recal_pending from any state.
- Pending is serviced only on a cycle where no downstream transfer is outstanding: state != ARMED, or energy_in_valid = 0, or (energy_in_valid and energy_out_ready).
- Servicing means: go to CAL, clear the accumulator and counters, config_valid = 0, and clear recal_pending. Thresholds hold their old values until recomputed.
- recal_req during CAL restarts calibration from frame 0.

Simultaneous events:
- recal service takes priority over clap/holdoff transitions in the same cycle.
- A frame accepted in the same cycle a state transition is decided is counted by the current state only.

Reset mid-operation returns to CAL with all outputs at their reset values; no partial frame is ever presented downstream.

Test Plan:
- Reset, then feed 16 frames of value 100 -> on cycle after 16th accept: thresh_high = 12800, thresh_low = 3200, config_valid = 1, no energy_out_valid during CAL.
- Calibrate with all frames 0 -> floor clamped to 1: thresh_high = 128, thresh_low = 32.
- Calibrate with frames 2^30 -> thresh_high = 2^35-1 (saturated), thresh_low = 2^35-1.
- ARMED with energy_out_ready toggling 1/0, frames 5, 6, 7 -> each appears on energy_out with the same cycle's valid; nothing lost or duplicated. Then suc_claps_fire with data = 2 -> HOLD, next 64 frames dropped, 65th forwarded.
- suc_claps_fire with data = 0 in ARMED -> stays ARMED. In HOLD at count 60, fire data = 1 -> counter restarts; 64 further frames dropped.
- ARMED, energy_in_valid = 1 and energy_out_ready = 0, pulse recal_req -> energy_out_valid held with stable data until ready = 1 accepts it, then next cycle state_calibrating = 1 and config_valid = 0. Synchronous reset asserted mid-HOLD -> CAL and all outputs at reset values on next edge.
